// File: rtl/phase_sequencer_if.sv
// Phase bus between the battle-phase sequencer and its phase responders.
// The sequencer (master) drives the phase code, turn index and phase-start
// strobe; each responder (slave) answers on its own busy/finished pair.
interface phase_sequencer_if;

    // Sequencer -> responders
    logic [3:0] state_out;
    logic [3:0] turn_out;
    logic       phase_start_out;

    // Menu responder handshake
    logic       menu_busy_in;
    logic       menu_finished_in;

    // Player-attack responder handshake
    logic       attack_busy_in;
    logic       attack_finished_in;

    // Enemy responder handshake
    logic       enemy_busy_in;
    logic       enemy_finished_in;

    modport master (
        output state_out,
        output turn_out,
        output phase_start_out,
        input  menu_busy_in,
        input  menu_finished_in,
        input  attack_busy_in,
        input  attack_finished_in,
        input  enemy_busy_in,
        input  enemy_finished_in
    );

    modport slave (
        input  state_out,
        input  turn_out,
        input  phase_start_out,
        output menu_busy_in,
        output menu_finished_in,
        output attack_busy_in,
        output attack_finished_in,
        output enemy_busy_in,
        output enemy_finished_in
    );

endinterface

// File: rtl/phase_sequencer.sv
// Battle-phase sequencer.
// Walks the battle through MENU -> ATTACK -> ENEMY phases with a short GAP
// between every pair of phases so each responder always sees the phase bus
// change. Each phase ends on the responder's finished pulse or on one of two
// watchdogs (busy never acknowledged, or phase overran). At each phase end the
// HP inputs decide whether the game continues, is won, or is lost.
module phase_sequencer #(
    parameter int          MAX_TURN      = 10,
    parameter int          GAP_CYCLES    = 4,
    parameter int          ACK_TIMEOUT   = 1024,
    parameter int unsigned PHASE_TIMEOUT = 32'd650000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [1:0]        menu_choice_in,
    input  logic [7:0]        player_hp_in,
    input  logic [7:0]        enemy_hp_in,
    phase_sequencer_if.master bus,
    output logic              timeout_out,
    output logic              game_over_out
);

    // Phase codes as seen by the responders on the shared bus.
    typedef enum logic [3:0] {
        ST_INIT   = 4'b1010,
        ST_GAP    = 4'b0000,
        ST_MENU   = 4'b0001,
        ST_ATTACK = 4'b0010,
        ST_ENEMY  = 4'b1000,
        ST_WIN    = 4'b1100,
        ST_LOSE   = 4'b1110
    } state_e;

    // Counter widths and terminal values.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LIMIT    = ACK_W'(ACK_TIMEOUT);
    localparam logic [31:0]      PHASE_LIMIT  = 32'(PHASE_TIMEOUT);
    localparam logic [3:0]       TURN_LAST    = 4'(MAX_TURN - 1);
    localparam logic [1:0]       CHOICE_MERCY = 2'b01;

    // Architectural state
    state_e           r_state;
    state_e           r_pending;     // phase to enter when the GAP expires
    logic [3:0]       r_turn;
    logic             r_phase_start;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [31:0]      r_phase_cnt;
    logic             r_busy_seen;

    // Next-state and decode nets
    state_e           w_next_state;
    state_e           w_next_pending;
    logic [3:0]       w_next_turn;
    logic             w_in_phase;
    logic             w_busy;
    logic             w_finished;
    logic             w_ack_expired;
    logic             w_phase_expired;
    logic             w_phase_end;
    logic             w_timeout;
    logic             w_stay_phase;
    logic             w_stay_gap;

    assign w_in_phase = (r_state == ST_MENU) ||
                        (r_state == ST_ATTACK) ||
                        (r_state == ST_ENEMY);

    // Select the handshake pair belonging to the current phase; all other
    // pairs, and every pair outside a phase, are ignored.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        w_busy     = 1'b0;
        w_finished = 1'b0;
        case (r_state)
            ST_MENU: begin
                w_busy     = bus.menu_busy_in;
                w_finished = bus.menu_finished_in;
            end
            ST_ATTACK: begin
                w_busy     = bus.attack_busy_in;
                w_finished = bus.attack_finished_in;
            end
            ST_ENEMY: begin
                w_busy     = bus.enemy_busy_in;
                w_finished = bus.enemy_finished_in;
            end
            default: ;
        endcase
    end

    // Watchdogs. A busy arriving on the very cycle the ack counter hits its
    // limit still counts as an acknowledge.
    assign w_ack_expired   = !(r_busy_seen || w_busy) && (r_ack_cnt == ACK_LIMIT);
    assign w_phase_expired = (r_phase_cnt == PHASE_LIMIT);

    // A finished pulse always wins over a watchdog firing on the same cycle.
    assign w_phase_end = w_in_phase && (w_finished || w_ack_expired || w_phase_expired);
    assign w_timeout   = w_in_phase && !w_finished && (w_ack_expired || w_phase_expired);

    // Phase sequencing: next state, pending phase and turn index.
    always_comb begin
        w_next_state   = r_state;
        w_next_pending = r_pending;
        w_next_turn    = r_turn;
        case (r_state)
            ST_INIT: begin
                if (start_in) begin
                    w_next_state   = ST_GAP;
                    w_next_pending = ST_MENU;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = r_pending;
                end
            end
            ST_MENU, ST_ATTACK, ST_ENEMY: begin
                if (w_phase_end) begin
                    // HP is judged on the ending cycle; a dead player loses
                    // even if the enemy died in the same exchange.
                    if (player_hp_in == 8'd0) begin
                        w_next_state = ST_LOSE;
                    end else if ((r_state == ST_ATTACK) && (enemy_hp_in == 8'd0)) begin
                        w_next_state = ST_WIN;
                    end else begin
                        w_next_state = ST_GAP;
                        case (r_state)
                            ST_MENU: begin
                                // Only 01 is MERCY; 00 and 1x both fight.
                                w_next_pending = (menu_choice_in == CHOICE_MERCY) ?
                                                 ST_ENEMY : ST_ATTACK;
                            end
                            ST_ATTACK: begin
                                w_next_pending = ST_ENEMY;
                            end
                            default: begin
                                // End of the enemy phase closes the turn.
                                w_next_pending = ST_MENU;
                                w_next_turn    = (r_turn == TURN_LAST) ? 4'd0 : r_turn + 4'd1;
                            end
                        endcase
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start_in) begin
                    w_next_state = ST_INIT;
                    w_next_turn  = 4'd0;
                end
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // State, pending phase, turn and phase-start strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_INIT;
            r_pending     <= ST_MENU;
            r_turn        <= 4'd0;
            r_phase_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its peers.
            r_state       <= w_next_state;
            r_pending     <= w_next_pending;
            r_turn        <= w_next_turn;
            // GAP only ever exits into a phase, so leaving GAP is phase entry.
            r_phase_start <= (r_state == ST_GAP) && (w_next_state != ST_GAP);
        end
    end

    // The counters run only while the FSM stays where it is; any transition
    // clears them, so the first cycle of a phase or GAP always sees zero.
    assign w_stay_phase = w_in_phase && (w_next_state == r_state);
    assign w_stay_gap   = (r_state == ST_GAP) && (w_next_state == ST_GAP);

    // GAP dwell counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= '0;
        end else if (w_stay_gap) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Ack and phase watchdog counters plus the busy-seen flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_cnt   <= '0;
            r_phase_cnt <= '0;
            r_busy_seen <= 1'b0;
        end else if (w_stay_phase) begin
            // Once busy has been seen the ack counter is ignored, so it is
            // free to wrap during a long phase.
            r_ack_cnt   <= r_ack_cnt + ACK_W'(1);
            r_phase_cnt <= r_phase_cnt + 32'd1;
            r_busy_seen <= r_busy_seen | w_busy;
        end else begin
            r_ack_cnt   <= '0;
            r_phase_cnt <= '0;
            r_busy_seen <= 1'b0;
        end
    end

    // Outputs. timeout_out is asserted on the phase's final cycle, the same
    // cycle whose edge moves the bus out of the phase.
    assign bus.state_out       = r_state;
    assign bus.turn_out        = r_turn;
    assign bus.phase_start_out = r_phase_start;
    assign timeout_out         = w_timeout;
    assign game_over_out       = (r_state == ST_WIN) || (r_state == ST_LOSE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer.
// Every cycle on which the bus changes, or a phase-start/timeout strobe fires,
// is an observed event. Stimulus tasks push the events they expect (cycle,
// phase, turn, strobes) into a queue; a negedge monitor pops and compares.
module tb_phase_sequencer;

    localparam int G   = 2;
    localparam int ACK = 4;
    localparam int PT  = 100;
    localparam int MT  = 3;

    localparam logic [3:0] S_INIT   = 4'b1010;
    localparam logic [3:0] S_GAP    = 4'b0000;
    localparam logic [3:0] S_MENU   = 4'b0001;
    localparam logic [3:0] S_ATTACK = 4'b0010;
    localparam logic [3:0] S_ENEMY  = 4'b1000;
    localparam logic [3:0] S_WIN    = 4'b1100;
    localparam logic [3:0] S_LOSE   = 4'b1110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic [1:0] menu_choice_in = 2'b00;
    logic [7:0] player_hp_in = 8'd20;
    logic [7:0] enemy_hp_in = 8'd20;
    logic       timeout_out;
    logic       game_over_out;

    phase_sequencer_if bus ();

    phase_sequencer #(
        .MAX_TURN      (MT),
        .GAP_CYCLES    (G),
        .ACK_TIMEOUT   (ACK),
        .PHASE_TIMEOUT (PT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .menu_choice_in (menu_choice_in),
        .player_hp_in   (player_hp_in),
        .enemy_hp_in    (enemy_hp_in),
        .bus            (bus),
        .timeout_out    (timeout_out),
        .game_over_out  (game_over_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [3:0] tn;
        logic       ps;
        logic       to;
        logic       go;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         cur_turn = 0;
    logic       mon_en = 1'b0;
    logic [3:0] prev_state = 4'b1010;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [3:0] st, input logic [3:0] tn,
                             input logic ps, input logic to);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.tn  = tn;
        e.ps  = ps;
        e.to  = to;
        e.go  = (st == S_WIN) || (st == S_LOSE);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every observed event against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((bus.state_out !== prev_state) || timeout_out || bus.phase_start_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_state", 32'(bus.state_out), 32'(prev_state));
                    check("spurious_timeout", 32'(timeout_out), 32'd0);
                    check("spurious_phase_start", 32'(bus.phase_start_out), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_cycle", cyc, mon_e.cyc);
                    check("ev_state", 32'(bus.state_out), 32'(mon_e.st));
                    check("ev_turn", 32'(bus.turn_out), 32'(mon_e.tn));
                    check("ev_phase_start", 32'(bus.phase_start_out), 32'(mon_e.ps));
                    check("ev_timeout", 32'(timeout_out), 32'(mon_e.to));
                    check("ev_game_over", 32'(game_over_out), 32'(mon_e.go));
                end
            end
            prev_state = bus.state_out;
        end
    end

    // Drive the pair matching the phase; hold the other pairs high as noise.
    task automatic drive_hs(input logic [3:0] ph, input logic b, input logic f);
        bus.menu_busy_in       = (ph == S_MENU)   ? b : 1'b1;
        bus.menu_finished_in   = (ph == S_MENU)   ? f : 1'b1;
        bus.attack_busy_in     = (ph == S_ATTACK) ? b : 1'b1;
        bus.attack_finished_in = (ph == S_ATTACK) ? f : 1'b1;
        bus.enemy_busy_in      = (ph == S_ENEMY)  ? b : 1'b1;
        bus.enemy_finished_in  = (ph == S_ENEMY)  ? f : 1'b1;
    endtask

    task automatic clear_hs();
        bus.menu_busy_in       = 1'b0;
        bus.menu_finished_in   = 1'b0;
        bus.attack_busy_in     = 1'b0;
        bus.attack_finished_in = 1'b0;
        bus.enemy_busy_in      = 1'b0;
        bus.enemy_finished_in  = 1'b0;
    endtask

    // Pulse start from INIT (runs through GAP to MENU entry) or from WIN/LOSE.
    task automatic press_start(input logic [3:0] from_st);
        start_in = 1'b1;
        if (from_st == S_INIT) begin
            expect_ev(cyc + 1, S_GAP, 4'(cur_turn), 1'b0, 1'b0);
            expect_ev(cyc + 1 + G, S_MENU, 4'(cur_turn), 1'b1, 1'b0);
        end else begin
            cur_turn = 0;
            expect_ev(cyc + 1, S_INIT, 4'd0, 1'b0, 1'b0);
        end
        tick();
        start_in = 1'b0;
        if (from_st == S_INIT) repeat (G) tick();
    endtask

    // Run one phase from its entry cycle. busy_at/fin_at are cycle offsets
    // from entry (-1 = never). Leaves the bench at the next phase entry, or
    // on the first WIN/LOSE cycle.
    task automatic run_phase(input logic [3:0] ph, input int busy_at, input int fin_at,
                             input logic [7:0] php, input logic [7:0] ehp,
                             input logic [1:0] choice);
        int         e_cyc;
        int         end_k;
        int         nturn;
        logic       to;
        logic [3:0] nxt;
        logic [3:0] pend;
        e_cyc = cyc;
        check("phase_entry_state", 32'(bus.state_out), 32'(ph));
        end_k = ((busy_at < 0) || (busy_at > ACK)) ? ACK : PT;
        to    = 1'b1;
        if ((fin_at >= 0) && (fin_at <= end_k)) begin
            end_k = fin_at;
            to    = 1'b0;
        end
        nturn = cur_turn;
        pend  = S_MENU;
        if (php == 8'd0) begin
            nxt = S_LOSE;
        end else if ((ph == S_ATTACK) && (ehp == 8'd0)) begin
            nxt = S_WIN;
        end else begin
            nxt = S_GAP;
            if (ph == S_MENU) begin
                pend = (choice == 2'b01) ? S_ENEMY : S_ATTACK;
            end else if (ph == S_ATTACK) begin
                pend = S_ENEMY;
            end else begin
                pend  = S_MENU;
                nturn = (cur_turn + 1) % MT;
            end
        end
        if (to) expect_ev(e_cyc + end_k, ph, 4'(cur_turn), 1'b0, 1'b1);
        expect_ev(e_cyc + end_k + 1, nxt, 4'(nturn), 1'b0, 1'b0);
        if (nxt == S_GAP) expect_ev(e_cyc + end_k + 1 + G, pend, 4'(nturn), 1'b1, 1'b0);

        player_hp_in   = php;
        enemy_hp_in    = ehp;
        menu_choice_in = choice;
        for (int k = 0; k <= end_k; k++) begin
            drive_hs(ph, (k == busy_at), (k == fin_at));
            start_in = (k == 2);   // start must be ignored inside a phase
            tick();
        end
        clear_hs();
        start_in = 1'b0;
        cur_turn = nturn;
        if (nxt == S_GAP) repeat (G) tick();
    endtask

    initial begin
        clear_hs();

        // Reset state
        #2 rst = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(bus.state_out), 32'(S_INIT));
        check("rst_turn", 32'(bus.turn_out), 32'd0);
        check("rst_phase_start", 32'(bus.phase_start_out), 32'd0);
        check("rst_timeout", 32'(timeout_out), 32'd0);
        check("rst_game_over", 32'(game_over_out), 32'd0);
        rst = 1'b1;
        prev_state = S_INIT;
        mon_en = 1'b1;
        tick();

        // 1-2: start, then a full MENU -> ATTACK -> ENEMY turn
        press_start(S_INIT);
        run_phase(S_MENU,   1, 10, 8'd20, 8'd5, 2'b00);
        run_phase(S_ATTACK, 1,  3, 8'd20, 8'd5, 2'b00);
        run_phase(S_ENEMY,  0,  5, 8'd20, 8'd5, 2'b00);          // turn -> 1

        // 3 + mercy: MENU MERCY skips ATTACK; ENEMY ack watchdog at cycle 4
        run_phase(S_MENU,  1,  2, 8'd20, 8'd5, 2'b01);
        run_phase(S_ENEMY, -1, -1, 8'd20, 8'd5, 2'b00);          // turn -> 2

        // 4: phase watchdog at 100, then finished exactly at 100 (no timeout)
        run_phase(S_MENU,   0,  1, 8'd20, 8'd5, 2'b10);          // 1x = FIGHT
        run_phase(S_ATTACK, 0, -1, 8'd20, 8'd5, 2'b00);
        run_phase(S_ENEMY,  1, 100, 8'd20, 8'd5, 2'b00);         // turn wraps -> 0

        // 5: one more turn, then LOSE has priority over enemy death
        run_phase(S_MENU,  0,  1, 8'd20, 8'd5, 2'b01);
        run_phase(S_ENEMY, 0,  2, 8'd20, 8'd5, 2'b00);           // turn -> 1
        run_phase(S_MENU,  0,  1, 8'd20, 8'd5, 2'b00);
        run_phase(S_ATTACK, 0, 3, 8'd0,  8'd0, 2'b00);           // LOSE
        tick();
        press_start(S_LOSE);                                     // INIT, turn 0
        tick();

        // WIN path via an ack timeout in MENU
        press_start(S_INIT);
        run_phase(S_MENU,   -1, -1, 8'd20, 8'd5, 2'b00);
        run_phase(S_ATTACK,  0,  2, 8'd20, 8'd0, 2'b00);         // WIN
        tick();
        press_start(S_WIN);
        tick();

        // 6: asynchronous reset in the middle of ENEMY
        press_start(S_INIT);
        run_phase(S_MENU, 0, 3, 8'd20, 8'd5, 2'b01);
        repeat (3) tick();
        cur_turn = 0;
        expect_ev(cyc, S_INIT, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state_out), 32'(S_INIT));
        check("async_rst_turn", 32'(bus.turn_out), 32'd0);
        check("async_rst_timeout", 32'(timeout_out), 32'd0);
        check("async_rst_phase_start", 32'(bus.phase_start_out), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Recovery after reset
        press_start(S_INIT);
        run_phase(S_MENU, 0, 1, 8'd20, 8'd5, 2'b00);
        repeat (3) tick();
        check("pending_events", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
